// File: rtl/riscv_pkg.sv
// Shared load/store definitions: access-size encodings and the lane
// helpers that map a core access onto a 32-bit memory word.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    // An access is illegal if its size code is unused or the address is not
    // a multiple of the access width.
    function automatic logic ldst_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            LDST_B, LDST_BU: mis = 1'b0;
            LDST_H, LDST_HU: mis = off[0];
            LDST_W:          mis = (off != 2'b00);
            default:         mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Byte enables for the addressed lanes.
    function automatic logic [3:0] ldst_be(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            LDST_B, LDST_BU: be = 4'b0001 << off;
            LDST_H, LDST_HU: be = 4'b0011 << {off[1], 1'b0};
            LDST_W:          be = 4'b1111;
            default:         be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated into every lane so the memory can pick any lane.
    function automatic logic [31:0] ldst_wd(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] rep;
        rep = wd;
        case (size)
            LDST_B, LDST_BU: rep = {4{wd[7:0]}};
            LDST_H, LDST_HU: rep = {2{wd[15:0]}};
            default:         rep = wd;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface riscv_lsu_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i, mem_ready_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_rd_i, mem_ready_i
    );
endinterface

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/half of a memory word and sign- or
// zero-extends it to 32 bits.
module lsu_load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension according to the access size.
    always_comb begin
        byte_s = 8'h00;
        case (offset_i)
            2'd0:    byte_s = word_i[7:0];
            2'd1:    byte_s = word_i[15:8];
            2'd2:    byte_s = word_i[23:16];
            2'd3:    byte_s = word_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (offset_i[1]) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
        case (size_i)
            LDST_B:  ext_o = {{24{byte_s[7]}}, byte_s};
            LDST_BU: ext_o = {24'h000000, byte_s};
            LDST_H:  ext_o = {{16{half_s[15]}}, half_s};
            LDST_HU: ext_o = {16'h0000, half_s};
            LDST_W:  ext_o = word_i;
            default: ext_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns a core byte/half/word access into a word-aligned
// memory transaction, stalls the core until the memory answers, and returns
// extended load data in the DONE cycle.
module riscv_lsu
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misaligned_o,
    riscv_lsu_if.master mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    lsu_state_e  state_q, state_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;

    logic        mis_s;
    logic        req_s;
    logic [1:0]  ext_off_s;
    logic [2:0]  ext_size_s;
    logic [31:0] ext_s;

    assign mis_s = ldst_misaligned(core_size_i, core_addr_i[1:0]);

    // A same-cycle ready in IDLE has no latched lane info yet, so extraction
    // uses the live core inputs there and the latched copy afterwards.
    assign ext_off_s  = (state_q == ST_IDLE) ? core_addr_i[1:0] : off_q;
    assign ext_size_s = (state_q == ST_IDLE) ? core_size_i      : size_q;

    lsu_load_extend u_load_extend (
        .word_i   (mem.mem_rd_i),
        .offset_i (ext_off_s),
        .size_i   (ext_size_s),
        .ext_o    (ext_s)
    );

    // Next-state, latch and read-data logic for the IDLE/WAIT/DONE sequence.
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        off_d   = off_q;
        rd_d    = rd_q;
        err_d   = err_q;
        req_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (core_req_i) begin
                    size_d = core_size_i;
                    off_d  = core_addr_i[1:0];
                    if (mis_s) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        rd_d    = 32'h0000_0000;
                    end else begin
                        req_s = 1'b1;
                        err_d = 1'b0;
                        if (mem.mem_ready_i) begin
                            state_d = ST_DONE;
                            if (!core_we_i) begin
                                rd_d = ext_s;
                            end else begin
                                rd_d = rd_q;
                            end
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Completes even if the core drops its request meanwhile.
                req_s = 1'b1;
                if (mem.mem_ready_i) begin
                    state_d = ST_DONE;
                    if (!core_we_i) begin
                        rd_d = ext_s;
                    end else begin
                        rd_d = rd_q;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
            rd_q    <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Reset gates the request directly so an abandoned access drops at once.
    assign mem.mem_req_o  = req_s & ~rst_i;
    assign mem.mem_we_o   = core_we_i;
    assign mem.mem_be_o   = ldst_be(core_size_i, core_addr_i[1:0]);
    assign mem.mem_addr_o = {core_addr_i[31:2], 2'b00};
    assign mem.mem_wd_o   = ldst_wd(core_size_i, core_wd_i);

    assign core_stall_o = core_req_i && (state_q != ST_DONE);
    assign core_rd_o    = rd_q;
    assign misaligned_o = err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed scenarios plus random
// transactions compared every cycle against a transaction-level model.
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = 32'h0;
    logic [31:0] core_wd_i = 32'h0;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        misaligned_o;

    riscv_lsu_if mb();

    riscv_lsu dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .misaligned_o (misaligned_o),
        .mem          (mb)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // expectations published by the driver for the current cycle
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_done, exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_addr, exp_rd;
    logic [31:0] model_rd = 32'h0;

    // observations for directed literal checks
    int          stall_cnt = 0;
    int          req_seen  = 0;
    logic [31:0] done_rd;
    logic        done_mis;
    logic [3:0]  req_be;
    logic [31:0] req_wd, req_addr;
    logic        req_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic m_mis(input logic [2:0] sz, input logic [1:0] off);
        if (sz == 3'd3 || sz >= 3'd6) return 1'b1;
        if ((sz == 3'd1 || sz == 3'd5) && off[0]) return 1'b1;
        if (sz == 3'd2 && off != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [1:0] off);
        if (sz == 3'd0 || sz == 3'd4) return 4'd1 << off;
        if (sz == 3'd1 || sz == 3'd5) return 4'd3 << off;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] wd);
        if (sz == 3'd0 || sz == 3'd4) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 3'd1 || sz == 3'd5) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] off, input logic [2:0] sz);
        logic [31:0] v;
        v = w >> {off, 3'b000};
        if (sz == 3'd2) return w;
        if (sz == 3'd0 || sz == 3'd4) begin
            v = v & 32'hFF;
            if (sz == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else begin
            v = v & 32'hFFFF;
            if (sz == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        if (chk_en) begin
            if (core_stall_o) stall_cnt++;
            if (mb.mem_req_o) begin
                req_seen++;
                req_be   = mb.mem_be_o;
                req_wd   = mb.mem_wd_o;
                req_addr = mb.mem_addr_o;
                req_we   = mb.mem_we_o;
            end
            chk("stall", {31'd0, core_stall_o}, {31'd0, exp_stall});
            chk("mem_req", {31'd0, mb.mem_req_o}, {31'd0, exp_req});
            if (exp_req) begin
                chk("mem_we", {31'd0, mb.mem_we_o}, {31'd0, exp_we});
                chk("mem_be", {28'd0, mb.mem_be_o}, {28'd0, exp_be});
                chk("mem_addr", mb.mem_addr_o, exp_addr);
                chk("mem_wd", mb.mem_wd_o, exp_wd);
            end
            if (exp_done) begin
                done_rd  = core_rd_o;
                done_mis = misaligned_o;
                chk("misaligned", {31'd0, misaligned_o}, {31'd0, exp_mis});
                chk("core_rd", core_rd_o, exp_rd);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycle();
        core_req_i     = 1'b0;
        mb.mem_ready_i = 1'($urandom_range(0, 1));
        mb.mem_rd_i    = $urandom;
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        exp_done  = 1'b0;
        step();
    endtask

    task automatic do_txn(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word, input int lat);
        logic [1:0] off;
        logic       err;
        off = addr[1:0];
        err = m_mis(sz, off);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = sz;
        core_addr_i = addr;
        core_wd_i   = wd;
        exp_we   = we;
        exp_be   = m_be(sz, off);
        exp_wd   = m_wd(sz, wd);
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_done = 1'b0;
        exp_stall = 1'b1;
        if (err) begin
            exp_req        = 1'b0;
            mb.mem_ready_i = 1'($urandom_range(0, 1));
            mb.mem_rd_i    = $urandom;
            step();
            model_rd = 32'h0;
        end else begin
            for (int k = 0; k <= lat; k++) begin
                exp_req        = 1'b1;
                mb.mem_ready_i = (k == lat);
                mb.mem_rd_i    = (k == lat) ? word : $urandom;
                step();
            end
            if (!we) model_rd = m_load(word, off, sz);
        end
        exp_req   = 1'b0;
        exp_stall = 1'b0;
        exp_done  = 1'b1;
        exp_mis   = err;
        exp_rd    = model_rd;
        mb.mem_ready_i = 1'($urandom_range(0, 1));
        mb.mem_rd_i    = $urandom;
        step();
        exp_done = 1'b0;
    endtask

    initial begin
        mb.mem_ready_i = 1'b0;
        mb.mem_rd_i    = 32'h0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
        exp_be = 4'h0; exp_wd = 32'h0; exp_addr = 32'h0; exp_rd = 32'h0;

        // model pins
        chk("model_lb", m_load(32'h80FF7F01, 2'd2, 3'd0), 32'hFFFF_FFFF);
        chk("model_lbu", m_load(32'h80FF7F01, 2'd3, 3'd4), 32'h0000_0080);
        chk("model_lh", m_load(32'h80FF7F01, 2'd2, 3'd1), 32'hFFFF_80FF);
        chk("model_sb_be", {28'd0, m_be(3'd0, 2'd3)}, 32'h0000_0008);
        chk("model_sb_wd", m_wd(3'd0, 32'h0000_00A5), 32'hA5A5_A5A5);

        // reset state
        #2;
        chk("rst_mem_req", {31'd0, mb.mem_req_o}, 32'd0);
        chk("rst_stall", {31'd0, core_stall_o}, 32'd0);
        chk("rst_mis", {31'd0, misaligned_o}, 32'd0);
        chk("rst_rd", core_rd_o, 32'd0);
        step();
        rst_i  = 1'b0;
        chk_en = 1'b1;

        // load word with three cycles of ready low
        stall_cnt = 0;
        do_txn(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 3);
        chk("lw_stall_cycles", stall_cnt, 32'd4);
        chk("lw_data", done_rd, 32'hDEADBEEF);

        // byte/half loads from 0x80FF7F01, same-cycle ready
        do_txn(1'b0, 3'd0, 32'h0000_0102, 32'h0, 32'h80FF7F01, 0);
        chk("lb_data", done_rd, 32'hFFFF_FFFF);
        do_txn(1'b0, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF7F01, 0);
        chk("lbu_data", done_rd, 32'h0000_0080);
        do_txn(1'b0, 3'd1, 32'h0000_0102, 32'h0, 32'h80FF7F01, 0);
        chk("lh_data", done_rd, 32'hFFFF_80FF);

        // store byte
        do_txn(1'b1, 3'd0, 32'h0000_0203, 32'h0000_00A5, 32'h0, 1);
        chk("sb_be", {28'd0, req_be}, 32'h0000_0008);
        chk("sb_wd", req_wd, 32'hA5A5_A5A5);
        chk("sb_addr", req_addr, 32'h0000_0200);
        chk("sb_we", {31'd0, req_we}, 32'd1);
        chk("sb_rd_kept", done_rd, 32'hFFFF_80FF);

        // misaligned accesses
        req_seen = 0;
        stall_cnt = 0;
        do_txn(1'b1, 3'd2, 32'h0000_0102, 32'h1234_5678, 32'h0, 0);
        chk("sw_mis_flag", {31'd0, done_mis}, 32'd1);
        do_txn(1'b0, 3'd1, 32'h0000_0101, 32'h0, 32'h0, 0);
        chk("lh_mis_flag", {31'd0, done_mis}, 32'd1);
        chk("lh_mis_rd", done_rd, 32'd0);
        chk("mis_no_req", req_seen, 32'd0);
        chk("mis_stall_cycles", stall_cnt, 32'd2);
        idle_cycle();

        // reset in the middle of a waiting request
        chk_en = 1'b0;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h0000_0300; mb.mem_ready_i = 1'b0;
        step();
        step();
        chk("wait_req_held", {31'd0, mb.mem_req_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_async_req", {31'd0, mb.mem_req_o}, 32'd0);
        chk("rst_async_rd", core_rd_o, 32'd0);
        chk("rst_stall_follows", {31'd0, core_stall_o}, 32'd1);
        core_req_i = 1'b0;
        step();
        #3 rst_i = 1'b0;
        step();
        model_rd = 32'h0;
        chk_en = 1'b1;
        do_txn(1'b0, 3'd5, 32'h0000_0302, 32'h0, 32'hCAFE1234, 2);
        chk("post_rst_lhu", done_rd, 32'h0000_CAFE);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit between the single-cycle core's data-memory port and the data memory. Converts the core's byte/half/word request (address, size, write data) into a word-aligned memory transaction with byte enables, waits on a variable-latency `mem_ready_i` handshake, and returns sign- or zero-extended load data. While the transaction is in flight it holds the core through `core_stall_o`, which drives the core's `stall_i`.

## Interface
Parameters: none.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- core_req_i  in  1  core requests a memory access this instruction
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5
- core_addr_i  in  32  byte address (ALU result)
- core_wd_i  in  32  store data (rs2)
- core_rd_o  out  32  extended load data
- core_stall_o  out  1  hold core PC and register-file write
- misaligned_o  out  1  misaligned or illegal-size access, valid in the DONE cycle
- mem_req_o  out  1  memory request, held until ready
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  `{core_addr_i[31:2], 2'b00}`
- mem_wd_o  out  32  lane-replicated write data
- mem_rd_i  in  32  memory read word, valid when `mem_ready_i`=1
- mem_ready_i  in  1  memory completes the request this cycle

## Operation
FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - `core_req_i`=1 and aligned: assert `mem_req_o`, latch size and `addr[1:0]`.
    - `mem_ready_i`=1: go to DONE.
    - `mem_ready_i`=0: go to WAIT.
  - `core_req_i`=1 and misaligned: go to DONE with the error latched. No memory request is issued.
- **WAIT**
  - `mem_req_o`=1, with `mem_we_o`, `mem_be_o`, `mem_addr_o` and `mem_wd_o` stable.
  - Go to DONE on `mem_ready_i`.
- **DONE**
  - `mem_req_o`=0, `core_stall_o`=0, and the core commits.
  - Next state is IDLE. Back-to-back memory instructions re-enter IDLE with a new request.
- `core_stall_o` = `core_req_i` && state != DONE.
- Misaligned conditions:
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]` != 0.
  - Size 3, 6 or 7.
  - The error sets `misaligned_o`=1 and `core_rd_o`=0 in DONE.
- Byte enables:
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011 << {addr[1],1'b0}`.
  - W: `4'b1111`.
- Write data:
  - B: `{4{wd[7:0]}}`.
  - H: `{2{wd[15:0]}}`.
  - W: `wd` unchanged.
- Load extraction uses the latched `addr[1:0]` and size:
  - B/H are sign-extended; BU/HU are zero-extended.
  - The result is registered on the `mem_ready_i` cycle and presented on `core_rd_o` in DONE.
- Stores leave the read register unchanged.
- `mem_ready_i` is ignored when `mem_req_o`=0.
- `core_req_i` falling while in WAIT is a protocol violation: the transaction completes anyway.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE; the read register and error flag are cleared.
  - `mem_req_o`, `core_stall_o`, `misaligned_o` = 0 (`core_stall_o` follows `core_req_i` after reset).
- Reset mid-WAIT abandons the request. `mem_req_o` drops asynchronously.
- Minimum latency is 2 cycles per memory instruction: the request cycle with ready, then DONE.
- Each extra cycle of `mem_ready_i` low adds one stall cycle.
- Misaligned accesses take exactly 2 cycles with zero memory requests.
- `core_stall_o`, `mem_req_o`, `mem_be_o`, `mem_wd_o` and `mem_addr_o` are combinational from state and core inputs.
- `core_rd_o` and `misaligned_o` are registered.

## Structure
- Shared `riscv_pkg`: LDST_B/H/W/BU/HU constants.
- The state enum stays local.
- One combinational sub-module, `lsu_load_extend`: inputs are word, offset and size; output is the extended 32-bit value.

## Test plan
- Load word, 3-cycle ready delay:
  - Stimulus: addr 0x100, `mem_rd_i` 0xDEADBEEF.
  - Response: stall for 4 cycles; `core_rd_o`=0xDEADBEEF in DONE; `mem_be_o`=1111 throughout.
- Byte loads, same-cycle ready, word 0x80FF7F01:
  - LB at offset 2 returns 0xFFFFFFFF.
  - LBU at offset 3 returns 0x00000080.
  - LH at offset 2 returns 0xFFFF80FF.
- Store byte:
  - Stimulus: addr 0x203, wd 0x000000A5.
  - Response: `mem_be_o`=1000, `mem_wd_o`=0xA5A5A5A5, `mem_addr_o`=0x200, `mem_we_o`=1.
- Misaligned accesses:
  - SW at 0x102 and LH at 0x101.
  - Response: `mem_req_o` never asserted; `misaligned_o`=1 in the 2nd cycle; `core_rd_o`=0.
- Reset mid-WAIT:
  - Response: `mem_req_o` drops without a clock edge.
  - A following load then completes normally with correct data.
